// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward-select codes, FSM states,
// and the width of the multi-cycle occupancy counter.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int MC_CNT_W = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding mux select for one Execute operand; purely combinational.
// Memory-stage result wins over Writeback; x0 is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic [1:0]        fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use stall, branch flush,
// multi-cycle Execute hold (MC_LAT cycles) and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              regwrite_e,
    input  logic              load_e,
    input  logic              mc_e,
    input  logic              pcsrc_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [MC_CNT_W-1:0] MC_INIT = MC_CNT_W'(MC_LAT - 2);

    state_t                state_q, state_d;
    logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [1:0]            fwd_a, fwd_b;
    logic                  load_use;
    logic                  st_f, st_d, st_e, fl_d, fl_e, busy;
    logic                  unused_regwrite_e;

    assign unused_regwrite_e = regwrite_e;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e       (rs1_e),
        .rd_m       (rd_m),
        .rd_w       (rd_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .fwd_sel    (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e       (rs2_e),
        .rd_m       (rd_m),
        .rd_w       (rd_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .fwd_sel    (fwd_b)
    );

    assign load_use = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Branch beats multi-cycle start beats load-use; a multi-cycle start
    // stalls Execute so it must never flush it in the same cycle.
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        st_f     = 1'b0;
        st_d     = 1'b0;
        st_e     = 1'b0;
        fl_d     = 1'b0;
        fl_e     = 1'b0;
        busy     = 1'b0;
        case (state_q)
            RUN: begin
                if (pcsrc_e) begin
                    fl_d = 1'b1;
                    fl_e = 1'b1;
                end else if (mc_e) begin
                    st_f     = 1'b1;
                    st_d     = 1'b1;
                    st_e     = 1'b1;
                    state_d  = MC_BUSY;
                    mc_cnt_d = MC_INIT;
                end else if (load_use) begin
                    st_f = 1'b1;
                    st_d = 1'b1;
                    fl_e = 1'b1;
                end
            end
            MC_BUSY: begin
                st_f = 1'b1;
                st_d = 1'b1;
                st_e = 1'b1;
                busy = 1'b1;
                if (mc_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
                end
            end
            default: begin
                state_d  = RUN;
                mc_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (st_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs depend on live inputs, so hold them quiet while reset is low.
    assign forward_a_e = rst ? fwd_a : FWD_RF;
    assign forward_b_e = rst ? fwd_b : FWD_RF;
    assign stall_f     = rst & st_f;
    assign stall_d     = rst & st_d;
    assign stall_e     = rst & st_e;
    assign flush_d     = rst & fl_d;
    assign flush_e     = rst & fl_e;
    assign mc_busy     = rst & busy;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl (MC_LAT=4, CNT_W=4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwrite_e, load_e, mc_e, pcsrc_e, regwrite_m, regwrite_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy;
    logic [3:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] exp_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .regwrite_e  (regwrite_e),
        .load_e      (load_e),
        .mc_e        (mc_e),
        .pcsrc_e     (pcsrc_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .regwrite_m  (regwrite_m),
        .regwrite_w  (regwrite_w),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .mc_busy     (mc_busy),
        .stall_cnt   (stall_cnt)
    );

    // flags = {regwrite_e, load_e, mc_e, pcsrc_e, regwrite_m, regwrite_w}
    // ex    = {stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy}
    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic [5:0] flags;
        logic [1:0] fa, fb;
        logic [5:0] ex;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name,
                                input logic [4:0] a_rs1_d, a_rs2_d, a_rs1_e, a_rs2_e,
                                input logic [4:0] a_rd_e, a_rd_m, a_rd_w,
                                input logic [5:0] flags, input logic [1:0] fa, fb,
                                input logic [5:0] ex);
        vec_t v;
        v.name  = name;
        v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
        v.rd_e  = a_rd_e;  v.rd_m  = a_rd_m;  v.rd_w  = a_rd_w;
        v.flags = flags;   v.fa = fa; v.fb = fb; v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
        rd_e  = v.rd_e;  rd_m  = v.rd_m;  rd_w  = v.rd_w;
        {regwrite_e, load_e, mc_e, pcsrc_e, regwrite_m, regwrite_w} = v.flags;
    endtask

    task automatic check_outs(input string name, input logic [1:0] fa, fb, input logic [5:0] ex);
        chk({name, ".fwd_a"},   16'(forward_a_e), 16'(fa));
        chk({name, ".fwd_b"},   16'(forward_b_e), 16'(fb));
        chk({name, ".stall_f"}, 16'(stall_f), 16'(ex[5]));
        chk({name, ".stall_d"}, 16'(stall_d), 16'(ex[4]));
        chk({name, ".stall_e"}, 16'(stall_e), 16'(ex[3]));
        chk({name, ".flush_d"}, 16'(flush_d), 16'(ex[2]));
        chk({name, ".flush_e"}, 16'(flush_e), 16'(ex[1]));
        chk({name, ".mc_busy"}, 16'(mc_busy), 16'(ex[0]));
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_outs(v.name, v.fa, v.fb, v.ex);
        @(posedge clk);
        if (v.ex[5] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        #1;
        chk({v.name, ".stall_cnt"}, 16'(stall_cnt), 16'(exp_cnt));
    endtask

    vec_t idle, lu, mc_go, busy_pc, pc_only;

    initial begin
        idle    = mk("idle",  0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'b00, 2'b00, 6'b000000);
        lu      = mk("sat_lu", 0, 7, 0, 0, 7, 0, 0, 6'b110000, 2'b00, 2'b00, 6'b110010);
        mc_go   = mk("mc_go", 0, 0, 0, 0, 0, 0, 0, 6'b001000, 2'b00, 2'b00, 6'b111000);
        busy_pc = mk("busy_pc", 0, 0, 0, 0, 0, 0, 0, 6'b000100, 2'b00, 2'b00, 6'b111001);
        pc_only = mk("pc_run", 0, 0, 0, 0, 0, 0, 0, 6'b000100, 2'b00, 2'b00, 6'b000110);

        //                       rs1d rs2d rs1e rs2e rde rdm rdw  flags      fa     fb     ex
        vecs.push_back(mk("fwd_m_prio", 0, 0, 5, 0, 0, 5, 5, 6'b000011, 2'b10, 2'b00, 6'b000000));
        vecs.push_back(mk("fwd_w_rdm0", 0, 0, 5, 0, 0, 0, 5, 6'b000011, 2'b01, 2'b00, 6'b000000));
        vecs.push_back(mk("fwd_b_wb",   0, 0, 1, 3, 0, 3, 3, 6'b000001, 2'b00, 2'b01, 6'b000000));
        vecs.push_back(mk("fwd_x0",     0, 0, 0, 0, 0, 0, 0, 6'b000011, 2'b00, 2'b00, 6'b000000));
        vecs.push_back(mk("fwd_both_m", 0, 0, 4, 4, 0, 4, 9, 6'b000011, 2'b10, 2'b10, 6'b000000));
        vecs.push_back(mk("lu_rs2",     0, 7, 0, 0, 7, 0, 0, 6'b110000, 2'b00, 2'b00, 6'b110010));
        vecs.push_back(mk("lu_x0",      0, 0, 0, 0, 0, 0, 0, 6'b110000, 2'b00, 2'b00, 6'b000000));
        vecs.push_back(mk("lu_vs_br",   7, 0, 0, 0, 7, 0, 0, 6'b110100, 2'b00, 2'b00, 6'b000110));
        vecs.push_back(mk("branch",     0, 0, 0, 0, 0, 0, 0, 6'b000100, 2'b00, 2'b00, 6'b000110));
        vecs.push_back(mk("no_load",    7, 0, 0, 0, 7, 0, 0, 6'b100000, 2'b00, 2'b00, 6'b000000));
        vecs.push_back(mk("lu_rs1",     2, 3, 0, 0, 2, 0, 0, 6'b110000, 2'b00, 2'b00, 6'b110010));
        // multi-cycle op: one RUN stall cycle, then three busy cycles ignoring branch/load-use
        vecs.push_back(mc_go);
        vecs.push_back(mk("busy1_fwd",  7, 0, 5, 0, 7, 5, 0, 6'b010110, 2'b10, 2'b00, 6'b111001));
        vecs.push_back(busy_pc);
        vecs.push_back(busy_pc);
        vecs.push_back(mk("mc_done",    0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'b00, 2'b00, 6'b000000));
        vecs.push_back(pc_only);

        // Reset: outputs quiet even with live hazards on the inputs
        rst = 1'b0;
        drive(mk("rst", 0, 7, 5, 5, 7, 5, 5, 6'b111111, 2'b00, 2'b00, 6'b000000));
        #3;
        check_outs("reset", 2'b00, 2'b00, 6'b000000);
        chk("reset.stall_cnt", 16'(stall_cnt), 16'd0);
        exp_cnt = 4'd0;
        @(negedge clk);
        drive(idle);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset in the second busy cycle
        apply(mc_go);
        @(negedge clk);
        drive(idle);
        @(posedge clk);
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        #1;
        chk("arst.pre_busy", 16'(mc_busy), 16'd1);
        drive(mk("arst_in", 0, 0, 5, 5, 0, 5, 5, 6'b000111, 2'b00, 2'b00, 6'b000000));
        rst = 1'b0;
        #1;
        check_outs("arst", 2'b00, 2'b00, 6'b000000);
        chk("arst.stall_cnt", 16'(stall_cnt), 16'd0);
        exp_cnt = 4'd0;
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        apply(mc_go);
        apply(busy_pc);
        apply(busy_pc);
        apply(busy_pc);
        apply(idle);

        // Continuous stalls drive the counter into saturation
        for (int k = 0; k < 18; k++) apply(lu);
        chk("sat.final", 16'(stall_cnt), 16'd15);
        apply(idle);
        chk("sat.hold", 16'(stall_cnt), 16'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
